// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the xgriscv hazard controller.
// Used by every hazard_ctrl file; HAZARD_PERF_CNT_EN adds the perf counters in the top.
package hazard_ctrl_pkg;
  localparam int RFIDX_WIDTH      = 5;
  localparam int WAIT_TIMEOUT_DEF = 255;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  // Wait counter is at least 8 bits, wider only if the timeout needs it.
  function automatic int wcnt_width(input int timeout);
    return (timeout > 255) ? $clog2(timeout + 1) : 8;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard sources in, stall/flush out.
// The master modport is the core datapath, the slave modport is hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [RFIDX_WIDTH-1:0] rs1D, rs2D, rdE;
  logic rs1_usedD, rs2_usedD;
  logic memtoregE, redirectE;
  logic dmem_reqM, dmem_readyM;
  logic stallF, stallD, flushD, flushE, stallE, stallM, flushW;

  modport master (
    output rs1D, rs2D, rs1_usedD, rs2_usedD, rdE, memtoregE, redirectE,
           dmem_reqM, dmem_readyM,
    input  stallF, stallD, flushD, flushE, stallE, stallM, flushW
  );

  modport slave (
    input  rs1D, rs2D, rs1_usedD, rs2_usedD, rdE, memtoregE, redirectE,
           dmem_reqM, dmem_readyM,
    output stallF, stallD, flushD, flushE, stallE, stallM, flushW
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with increment enable; sticks at all-ones.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rstn)              cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for load-use, redirect and data-memory wait hazards.
// Define HAZARD_PERF_CNT_EN to add the lu/memwait/redirect performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  hazard_ctrl_if.slave         hz,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] lu_cnt,
  output logic [CNT_WIDTH-1:0] memwait_cnt,
  output logic [CNT_WIDTH-1:0] redirect_cnt,
`endif
  output logic                 err_timeout
);
  localparam int WCW = wcnt_width(WAIT_TIMEOUT);
  localparam logic [WCW-1:0] TO = WCW'(WAIT_TIMEOUT);

  hz_state_e      state;
  logic [WCW-1:0] wcnt;

  logic lu, freeze, run_ok, redir, lu_hold;

  always_comb begin
    lu = hz.memtoregE && (hz.rdE != '0) &&
         ((hz.rs1_usedD && (hz.rdE == hz.rs1D)) ||
          (hz.rs2_usedD && (hz.rdE == hz.rs2D)));
    // Waiting state keeps the freeze until ready, regardless of the request level.
    freeze  = rstn && ((state == HZ_RUN)      ? (hz.dmem_reqM && !hz.dmem_readyM)
                                              : !hz.dmem_readyM);
    run_ok  = rstn && (state == HZ_RUN) && !freeze;
    redir   = run_ok && hz.redirectE;
    lu_hold = run_ok && lu && !hz.redirectE;

    hz.stallF = freeze | lu_hold;
    hz.stallD = freeze | lu_hold;
    hz.flushD = redir;
    hz.flushE = redir | lu_hold;
    hz.stallE = freeze;
    hz.stallM = freeze;
    hz.flushW = freeze;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= HZ_RUN;
      wcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (freeze) begin
            state <= HZ_MEM_WAIT;
            wcnt  <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (hz.dmem_readyM) state <= HZ_RUN;
          // Timeout only flags; the freeze carries on until memory answers.
          if (wcnt != TO) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt + 1'b1 == TO) err_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_WIDTH)) u_lu_cnt (
    .clk(clk), .rstn(rstn), .inc(lu_hold), .cnt(lu_cnt)
  );
  hazard_perf_cnt #(.W(CNT_WIDTH)) u_memwait_cnt (
    .clk(clk), .rstn(rstn), .inc(freeze), .cnt(memwait_cnt)
  );
  hazard_perf_cnt #(.W(CNT_WIDTH)) u_redirect_cnt (
    .clk(clk), .rstn(rstn), .inc(redir), .cnt(redirect_cnt)
  );
`endif
endmodule
